led_bank_ctrl: RTL

Parametrised memory-mapped LED output controller for the Minisys I/O space, successor to the fixed 24-bit LED port. It drives NUM_BANKS banks of 8 LEDs from halfword-addressed data registers with byte enables. It adds read-back and per-bank hardware blinking driven by a programmable prescaled timebase. The block sits on the CPU I/O bus behind the address decoder's LED chip-select.

---
 rtl/led_bank_ctrl_if.sv | 20 ++
 rtl/led_bank_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/led_bank_ctrl_if.sv
// CPU I/O bus bundle seen by the LED controller behind its chip-select.
interface led_bank_ctrl_if;
  logic        Select;
  logic        Write_enable;
  logic        Read_enable;
  logic [2:0]  Address;
  logic [1:0]  Byte_enable;
  logic [15:0] Write_data_in;
  logic [15:0] Read_data_out;

  modport master (
    output Select, Write_enable, Read_enable, Address, Byte_enable, Write_data_in,
    input  Read_data_out
  );

  modport slave (
    input  Select, Write_enable, Read_enable, Address, Byte_enable, Write_data_in,
    output Read_data_out
  );
endinterface

// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank controller: byte-enabled data registers, read-back,
// and per-bank blinking from a prescaled timebase.
module led_bank_ctrl #(
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned PRESCALE  = 10000
) (
  input  logic                   clock,
  input  logic                   reset,
  led_bank_ctrl_if.slave         bus,
  output logic [8*NUM_BANKS-1:0] led_out
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]           bank_q [NUM_BANKS];
  logic [NUM_BANKS-1:0] mode_q;
  logic [15:0]          period_q;
  logic [PW-1:0]        presc_q;
  logic [15:0]          tick_cnt_q;
  logic                 phase_q;

  logic        wr;
  logic        rd;
  logic        period_wr;
  logic        tick;
  logic [15:0] rd_mux;

  assign wr        = bus.Select && bus.Write_enable;
  assign rd        = bus.Select && bus.Read_enable && !bus.Write_enable;
  assign period_wr = wr && (bus.Address == 3'd5) && (|bus.Byte_enable);
  assign tick      = (presc_q == PW'(PRESCALE - 1));

  // Register file writes; bytes of absent banks simply have no storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
      mode_q   <= '0;
      period_q <= '0;
    end else if (wr) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (bus.Address == 3'(b >> 1)) begin
          if (b[0] && bus.Byte_enable[1])  bank_q[b] <= bus.Write_data_in[15:8];
          if (!b[0] && bus.Byte_enable[0]) bank_q[b] <= bus.Write_data_in[7:0];
        end
      end
      if (bus.Address == 3'd4 && bus.Byte_enable[0])
        mode_q <= bus.Write_data_in[NUM_BANKS-1:0];
      if (bus.Address == 3'd5) begin
        if (bus.Byte_enable[0]) period_q[7:0]  <= bus.Write_data_in[7:0];
        if (bus.Byte_enable[1]) period_q[15:8] <= bus.Write_data_in[15:8];
      end
    end
  end

  // Blink timebase; a PERIOD write restarts it and overrides a coincident tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b1;
    end else if (period_wr) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (period_q == '0) begin
        tick_cnt_q <= '0;
        phase_q    <= 1'b1;
      end else if (tick) begin
        if (tick_cnt_q == period_q - 16'd1) begin
          tick_cnt_q <= '0;
          phase_q    <= ~phase_q;
        end else begin
          tick_cnt_q <= tick_cnt_q + 16'd1;
        end
      end
    end
  end

  // Read-back multiplexer over the register map.
  always_comb begin
    rd_mux = '0;
    if (!bus.Address[2]) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (bus.Address == 3'(b >> 1)) begin
          if (b[0]) rd_mux[15:8] = bank_q[b];
          else      rd_mux[7:0]  = bank_q[b];
        end
      end
    end else begin
      case (bus.Address[1:0])
        2'd0:    rd_mux[NUM_BANKS-1:0] = mode_q;
        2'd1:    rd_mux = period_q;
        2'd2:    rd_mux[0] = phase_q;
        default: rd_mux = '0;
      endcase
    end
  end

  // Read data is a one-cycle pulse; any edge without a clean read loads 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus.Read_data_out <= '0;
    else        bus.Read_data_out <= rd ? rd_mux : '0;
  end

  // LED drive: a blinking bank is gated by the phase, others are steady.
  always_comb begin
    led_out = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      led_out[8*b +: 8] = bank_q[b] & {8{~mode_q[b] | phase_q}};
  end

endmodule
